nibble_serial_adder: RTL

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Bit-serial-by-nibble adder/subtractor. An accepted operation is processed
//   one 4-bit slice per clock, LSB nibble first, and the result is held until
//   the consumer takes it.
//
//   Ports
//     clk, rst          clock, asynchronous active-high reset
//     in_valid/in_ready operand handshake (in_ready only in IDLE, rst low)
//     inA, inB          operands (WIDTH bits, WIDTH multiple of 4, >= 8)
//     Cin               carry-in, used only when sub=0
//     sub               1: A - B, 0: A + B + Cin
//     out_valid/out_ready result handshake (out_valid only in DONE)
//     Sum, Cout         result and carry out of the MSB (Cout=1: no borrow)
//     Ofl               two's-complement signed overflow
//     Zero              Sum == 0
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ofl,
  output logic             Zero
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned CW   = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ofl_q, ofl_d;
  logic             zero_q, zero_d;

  logic [4:0]       nib_full;
  logic             c_into_msb;
  logic [WIDTH-1:0] sum_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ofl_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ofl_q   <= ofl_d;
      zero_q  <= zero_d;
    end
  end

  // Operands are shifted right one nibble per RUN edge so the active slice is
  // always bits [3:0]; result nibbles enter at the top of sum_q, so after
  // WIDTH/4 edges nibble k lands in Sum[4k+3:4k].
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    c_d        = c_q;
    cout_d     = cout_q;
    ofl_d      = ofl_q;
    zero_d     = zero_q;

    nib_full   = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, c_q};
    // Carry into bit 3 recovered from its sum bit: s3 = a3 ^ b3 ^ c3.
    c_into_msb = nib_full[3] ^ a_q[3] ^ b_q[3];
    sum_shift  = {nib_full[3:0], sum_q[WIDTH-1:4]};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = inA;
          b_d     = sub ? ~inB : inB;
          c_d     = sub ? 1'b1 : Cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = {4'b0, a_q[WIDTH-1:4]};
        b_d   = {4'b0, b_q[WIDTH-1:4]};
        sum_d = sum_shift;
        c_d   = nib_full[4];
        if (cnt_q == LAST) begin
          cout_d  = nib_full[4];
          ofl_d   = c_into_msb ^ nib_full[4];
          zero_d  = (sum_shift == '0);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ofl       = ofl_q;
  assign Zero      = zero_q;

endmodule
